block_commit_ctrl: RTL and testbench

- Initiator-side controller for the two-slot transaction/hash RAM (48-bit transaction slot, 8-bit previous-hash slot).
- Accepts new transactions from the player logic and writes them into the RAM.
- On a commit request, reads back the transaction and the previous hash, mixes them into a new 8-bit hash over 6 cycles, and writes the result into the hash slot as the next block's previous hash.

---
 rtl/block_commit_ctrl.sv | 148 ++++++++++++++
 tb/tb_block_commit_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/block_commit_ctrl.sv
// Initiator-side controller for the two-slot transaction/hash RAM.
// Stores incoming transactions and, on commit, folds the stored transaction into the previous hash.
module block_commit_ctrl #(
    parameter logic [7:0]  HASH_ADD  = 8'h1D,
    parameter int unsigned NUM_BYTES = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic [47:0] tx_data,
    output logic        tx_ready,
    input  logic        commit,
    output logic        busy,
    output logic        done,
    output logic [7:0]  new_hash,
    output logic        ram_access_type,
    output logic [47:0] ram_data_out,
    output logic        ram_wren,
    input  logic [47:0] ram_result
);

    localparam int unsigned TX_W   = 48;
    localparam int unsigned HASH_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_TX,
        S_RD_TX,
        S_RD_HASH,
        S_MIX,
        S_WR_HASH,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [TX_W-1:0]     tx_buf_q, tx_buf_d;
    logic [HASH_W-1:0]   h_q, h_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HASH_W-1:0]   new_hash_q, new_hash_d;
    logic [HASH_W-1:0]   mix_byte;
    logic                last_byte;

    assign mix_byte  = tx_buf_q[{idx_q, 3'b000} +: HASH_W];
    assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a transaction offer wins over a simultaneous commit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_WR_TX;
                end else if (commit) begin
                    state_d = S_RD_TX;
                end
            end
            S_WR_TX:   state_d = S_IDLE;
            S_RD_TX:   state_d = S_RD_HASH;
            S_RD_HASH: state_d = S_MIX;
            S_MIX:     state_d = last_byte ? S_WR_HASH : S_MIX;
            S_WR_HASH: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode; write enable is gated by reset so an aborted write never lands
    always_comb begin
        tx_ready        = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        ram_access_type = 1'b0;
        ram_data_out    = '0;
        ram_wren        = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            S_WR_TX: begin
                ram_wren     = ~reset;
                ram_data_out = tx_buf_q;
            end
            S_RD_HASH: ram_access_type = 1'b1;
            S_WR_HASH: begin
                ram_access_type = 1'b1;
                ram_wren        = ~reset;
                ram_data_out    = {{(TX_W - HASH_W){1'b0}}, h_q};
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        tx_buf_d   = tx_buf_q;
        h_d        = h_q;
        idx_d      = idx_q;
        new_hash_d = new_hash_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_buf_d = tx_data;
                end
            end
            S_RD_TX: tx_buf_d = ram_result;
            S_RD_HASH: begin
                h_d   = ram_result[HASH_W-1:0];
                idx_d = '0;
            end
            S_MIX: begin
                h_d   = ({h_q[HASH_W-2:0], h_q[HASH_W-1]} ^ mix_byte) + HASH_ADD;
                idx_d = idx_q + IDX_W'(1);
            end
            S_DONE:  new_hash_d = h_q;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_buf_q   <= '0;
            h_q        <= '0;
            idx_q      <= '0;
            new_hash_q <= '0;
        end else begin
            tx_buf_q   <= tx_buf_d;
            h_q        <= h_d;
            idx_q      <= idx_d;
            new_hash_q <= new_hash_d;
        end
    end

    assign new_hash = new_hash_q;

endmodule

// File: tb/tb_block_commit_ctrl.sv
// Directed bench for block_commit_ctrl with a two-slot RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_block_commit_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [47:0] tx_data;
    logic        tx_ready;
    logic        commit;
    logic        busy;
    logic        done;
    logic [7:0]  new_hash;
    logic        ram_access_type;
    logic [47:0] ram_data_out;
    logic        ram_wren;
    logic [47:0] ram_result;

    logic        ram_clear;
    logic [47:0] ram_tx;
    logic [7:0]  ram_hash;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int wren_cnt  = 0;

    always #5 clock = ~clock;

    block_commit_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .commit          (commit),
        .busy            (busy),
        .done            (done),
        .new_hash        (new_hash),
        .ram_access_type (ram_access_type),
        .ram_data_out    (ram_data_out),
        .ram_wren        (ram_wren),
        .ram_result      (ram_result)
    );

    // RAM model: transaction slot and hash slot, cleared to 0 / FF
    always @(posedge clock) begin
        if (ram_clear) begin
            ram_tx   <= 48'h0;
            ram_hash <= 8'hFF;
        end else if (ram_wren) begin
            if (ram_access_type) ram_hash <= ram_data_out[7:0];
            else                 ram_tx   <= ram_data_out;
        end
    end

    assign ram_result = ram_access_type ? {40'h0, ram_hash} : ram_tx;

    always @(negedge clock) begin
        if (done)     done_cnt = done_cnt + 1;
        if (ram_wren) wren_cnt = wren_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        ram_clear = 1'b1;
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        ram_clear = 1'b0;
    endtask

    // Entered at a falling edge in IDLE; returns at the falling edge of the IDLE cycle after DONE
    task automatic run_commit(input string tag, input logic [7:0] exp_prev,
                              input logic [7:0] exp_hash, input bit toggle);
        int d0, w0;
        d0 = done_cnt;
        w0 = wren_cnt;
        commit = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            commit   = toggle & c[0];
            tx_valid = toggle & ~c[0];
            if (c == 10) begin
                commit   = 1'b0;
                tx_valid = 1'b0;
            end
            check_eq({tag, "_busy"}, 48'(busy), 48'h1);
            if (c == 2) begin
                check_eq({tag, "_rd_hash_type"}, 48'(ram_access_type), 48'h1);
                check_eq({tag, "_prev_hash"}, 48'(ram_result[7:0]), 48'(exp_prev));
            end
            if (c == 9) begin
                check_eq({tag, "_wr_hash_wren"}, 48'(ram_wren), 48'h1);
                check_eq({tag, "_wr_hash_data"}, ram_data_out, 48'(exp_hash));
            end
            if (c == 10) check_eq({tag, "_done"}, 48'(done), 48'h1);
        end
        @(negedge clock);
        check_eq({tag, "_new_hash"}, 48'(new_hash), 48'(exp_hash));
        check_eq({tag, "_idle"}, 48'({busy, tx_ready}), 48'b01);
        check_eq({tag, "_done_count"}, 48'(done_cnt - d0), 48'd1);
        check_eq({tag, "_wren_count"}, 48'(wren_cnt - w0), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        reset     = 1'b1;
        ram_clear = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 48'h0;
        commit    = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_tx_ready", 48'(tx_ready), 48'h1);
        check_eq("rst_busy", 48'(busy), 48'h0);
        check_eq("rst_done", 48'(done), 48'h0);
        check_eq("rst_new_hash", 48'(new_hash), 48'h0);
        check_eq("rst_ram_side", {ram_data_out[46:0], ram_wren}, 48'h0);
        check_eq("rst_access", 48'(ram_access_type), 48'h0);

        // Commit from reset RAM, then chain a second commit immediately
        run_commit("c1", 8'hFF, 8'h09, 1'b0);
        run_commit("c2", 8'h09, 8'h64, 1'b0);

        // Store tx=1, then commit from a fresh hash: LSB byte first
        do_reset();
        tx_data  = 48'h000000000001;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check_eq("wrtx_wren", 48'(ram_wren), 48'h1);
        check_eq("wrtx_data", ram_data_out, 48'h1);
        check_eq("wrtx_type", 48'(ram_access_type), 48'h0);
        check_eq("wrtx_ready", 48'(tx_ready), 48'h0);
        @(negedge clock);
        check_eq("wrtx_idle_wren", 48'(ram_wren), 48'h0);
        check_eq("wrtx_stored", ram_tx, 48'h1);
        run_commit("c3", 8'hFF, 8'hE9, 1'b0);

        // tx_valid and commit together: write wins, commit dropped
        tx_data  = 48'h000000000002;
        tx_valid = 1'b1;
        commit   = 1'b1;
        d0 = done_cnt;
        @(negedge clock);
        tx_valid = 1'b0;
        commit   = 1'b0;
        check_eq("both_busy", 48'(busy), 48'h1);
        check_eq("both_wren", 48'(ram_wren), 48'h1);
        check_eq("both_data", ram_data_out, 48'h2);
        @(negedge clock);
        check_eq("both_idle", 48'({busy, tx_ready}), 48'b01);
        check_eq("both_stored", ram_tx, 48'h2);
        repeat (12) @(negedge clock);
        check_eq("both_no_done", 48'(done_cnt - d0), 48'h0);

        // Reset during MIX aborts without any RAM write
        d0 = done_cnt;
        w0 = wren_cnt;
        commit = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            commit = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("abort_ready", 48'(tx_ready), 48'h1);
        check_eq("abort_busy", 48'(busy), 48'h0);
        check_eq("abort_new_hash", 48'(new_hash), 48'h0);
        check_eq("abort_no_wren", 48'(wren_cnt - w0), 48'h0);
        check_eq("abort_no_done", 48'(done_cnt - d0), 48'h0);
        check_eq("abort_hash_slot", 48'(ram_hash), 48'hE9);

        // Reset arriving during WR_TX suppresses the write at once
        tx_data  = 48'h000000000ABC;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check_eq("gate_wren_pre", 48'(ram_wren), 48'h1);
        #1 reset = 1'b1;
        #1 check_eq("gate_wren_rst", 48'(ram_wren), 48'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("gate_tx_slot", ram_tx, 48'h2);
        check_eq("gate_idle", 48'({busy, tx_ready}), 48'b01);

        // Commit with commit/tx_valid toggling while busy (prev E9, tx 2)
        tx_data = 48'hFFFFFFFFFFFF;
        run_commit("c4", 8'hE9, 8'h5C, 1'b1);
        check_eq("c4_tx_slot", ram_tx, 48'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
